// File: rtl/cpu_control.sv
// Main control decoder: maps the instruction opcode onto registered datapath
// control strobes, with a synchronous flush that inserts an all-zero bubble.
module cpu_control #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned ALUOP_W  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [ALUOP_W-1:0]  aluOP,
   output logic                regWrite,
   output logic                regDesination,
   output logic                aluSource,
   output logic                Branch,
   output logic                memWrite,
   output logic                memToReg,
   output logic                jump,
   output logic                jal,
   output logic                jr,
   output logic                mem_read,
   output logic                illegal_op
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_ADDI  = 6'b000001,
      OP_LW    = 6'b000010,
      OP_SW    = 6'b000011,
      OP_BEQ   = 6'b000100,
      OP_ANDI  = 6'b000101,
      OP_JUMP  = 6'b001000,
      OP_JAL   = 6'b001001,
      OP_JR    = 6'b001010
   } opcode_e;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_AND   = 2'b11
   } aluop_e;

   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic               reg_write;
      logic               reg_dst;
      logic               alu_src;
      logic               branch;
      logic               mem_write;
      logic               mem_to_reg;
      logic               jump;
      logic               jal;
      logic               jr;
      logic               mem_read;
      logic               illegal;
   } ctrl_t;

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   always_comb begin
      ctrl_d = '0;
      if (!flush) begin
         case (opcode)
            OP_RTYPE: begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.reg_dst   = 1'b1;
               ctrl_d.alu_op    = ALU_FUNCT;
            end
            OP_ADDI: begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.alu_op    = ALU_ADD;
            end
            OP_LW: begin
               ctrl_d.reg_write  = 1'b1;
               ctrl_d.alu_src    = 1'b1;
               ctrl_d.mem_to_reg = 1'b1;
               ctrl_d.mem_read   = 1'b1;
               ctrl_d.alu_op     = ALU_ADD;
            end
            OP_SW: begin
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.mem_write = 1'b1;
               ctrl_d.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
               ctrl_d.branch = 1'b1;
               ctrl_d.alu_op = ALU_SUB;
            end
            OP_ANDI: begin
               ctrl_d.reg_write = 1'b1;
               ctrl_d.alu_src   = 1'b1;
               ctrl_d.alu_op    = ALU_AND;
            end
            OP_JUMP: ctrl_d.jump = 1'b1;
            OP_JAL: begin
               ctrl_d.jump      = 1'b1;
               ctrl_d.jal       = 1'b1;
               ctrl_d.reg_write = 1'b1;
            end
            OP_JR:   ctrl_d.jr = 1'b1;
            default: ctrl_d.illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ctrl_q <= '0;
      else        ctrl_q <= ctrl_d;
   end

   assign aluOP         = ctrl_q.alu_op;
   assign regWrite      = ctrl_q.reg_write;
   assign regDesination = ctrl_q.reg_dst;
   assign aluSource     = ctrl_q.alu_src;
   assign Branch        = ctrl_q.branch;
   assign memWrite      = ctrl_q.mem_write;
   assign memToReg      = ctrl_q.mem_to_reg;
   assign jump          = ctrl_q.jump;
   assign jal           = ctrl_q.jal;
   assign jr            = ctrl_q.jr;
   assign mem_read      = ctrl_q.mem_read;
   assign illegal_op    = ctrl_q.illegal;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed scenarios plus random opcode/flush
// traffic compared against a table-driven reference model.
module tb_cpu_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic [5:0] opcode = '0;
   logic [1:0] aluOP;
   logic regWrite, regDesination, aluSource, Branch, memWrite, memToReg;
   logic jump, jal, jr, mem_read, illegal_op;

   int total = 0;
   int bad   = 0;

   // Packed view: {illegal, mem_read, jr, jal, jump, memToReg, memWrite,
   //               Branch, aluSource, regDesination, regWrite, aluOP[1:0]}
   logic [12:0] tbl [logic [5:0]];

   cpu_control #(.OPCODE_W(6), .ALUOP_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .opcode(opcode),
      .aluOP(aluOP), .regWrite(regWrite), .regDesination(regDesination),
      .aluSource(aluSource), .Branch(Branch), .memWrite(memWrite),
      .memToReg(memToReg), .jump(jump), .jal(jal), .jr(jr),
      .mem_read(mem_read), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] pack(input bit ill, input bit mrd, input bit fjr,
                                        input bit fjal, input bit fj, input bit m2r,
                                        input bit mwr, input bit br, input bit asrc,
                                        input bit rdst, input bit rwr, input bit [1:0] aop);
      return {ill, mrd, fjr, fjal, fj, m2r, mwr, br, asrc, rdst, rwr, aop};
   endfunction

   function automatic logic [12:0] observed();
      return {illegal_op, mem_read, jr, jal, jump, memToReg, memWrite,
              Branch, aluSource, regDesination, regWrite, aluOP};
   endfunction

   function automatic logic [12:0] model(input logic [5:0] op, input logic fl);
      if (fl) return '0;
      if (tbl.exists(op)) return tbl[op];
      return pack(1,0,0,0,0,0,0,0,0,0,0,2'b00);
   endfunction

   task automatic build_table();
      //                 ill mrd jr jal j m2r mwr br asrc rdst rwr aop
      tbl[6'b000000] = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b10);
      tbl[6'b000001] = pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00);
      tbl[6'b000010] = pack(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2'b00);
      tbl[6'b000011] = pack(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00);
      tbl[6'b000100] = pack(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01);
      tbl[6'b000101] = pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b11);
      tbl[6'b001000] = pack(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[6'b001001] = pack(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2'b00);
      tbl[6'b001010] = pack(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
   endtask

   task automatic step(input logic [5:0] op, input logic fl);
      opcode = op;
      flush  = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      opcode = 6'b000010;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (observed() !== 13'h0) begin
         bad++;
         $display("FAIL reset_hold: got %h want %h", observed(), 13'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(6'b000010, 1'b0);
      total++;
      if (observed() !== pack(0,1,0,0,0,1,0,0,1,0,1,2'b00)) begin
         bad++;
         $display("FAIL reset_release_lw: got %h want %h", observed(),
                  pack(0,1,0,0,0,1,0,0,1,0,1,2'b00));
      end
   endtask

   task automatic test_sequence();
      logic [5:0] seq [7] = '{6'b000000, 6'b000010, 6'b000011, 6'b000101,
                              6'b001000, 6'b001001, 6'b001100};
      for (int i = 0; i < 7; i++) begin
         step(seq[i], 1'b0);
         total++;
         if (observed() !== model(seq[i], 1'b0)) begin
            bad++;
            $display("FAIL seq[%0d] op=%b: got %h want %h", i, seq[i], observed(),
                     model(seq[i], 1'b0));
         end
      end
   endtask

   task automatic test_addi_beq_jr();
      logic [5:0] seq [3] = '{6'b000001, 6'b000100, 6'b001010};
      for (int i = 0; i < 3; i++) begin
         step(seq[i], 1'b0);
         total++;
         if (observed() !== model(seq[i], 1'b0)) begin
            bad++;
            $display("FAIL addi_beq_jr op=%b: got %h want %h", seq[i], observed(),
                     model(seq[i], 1'b0));
         end
      end
   endtask

   task automatic test_flush();
      step(6'b001001, 1'b1);
      total++;
      if (observed() !== 13'h0) begin
         bad++;
         $display("FAIL flush_jal: got %h want %h", observed(), 13'h0);
      end
      step(6'b001001, 1'b0);
      total++;
      if (observed() !== pack(0,0,0,1,1,0,0,0,0,0,1,2'b00)) begin
         bad++;
         $display("FAIL flush_release_jal: got %h want %h", observed(),
                  pack(0,0,0,1,1,0,0,0,0,0,1,2'b00));
      end
      step(6'b111111, 1'b1);
      total++;
      if (illegal_op !== 1'b0) begin
         bad++;
         $display("FAIL flush_illegal: got %b want 0", illegal_op);
      end
   endtask

   task automatic test_async_reset();
      step(6'b000000, 1'b0);
      total++;
      if (observed() !== pack(0,0,0,0,0,0,0,0,0,1,1,2'b10)) begin
         bad++;
         $display("FAIL async_pre_rtype: got %h want %h", observed(),
                  pack(0,0,0,0,0,0,0,0,0,1,1,2'b10));
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (observed() !== 13'h0) begin
         bad++;
         $display("FAIL async_clear: got %h want %h", observed(), 13'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(6'b000100, 1'b0);
      total++;
      if (observed() !== model(6'b000100, 1'b0)) begin
         bad++;
         $display("FAIL async_release_beq: got %h want %h", observed(),
                  model(6'b000100, 1'b0));
      end
   endtask

   task automatic test_sweep();
      int n_illegal = 0;
      for (int i = 0; i < 64; i++) begin
         logic [5:0] op = 6'(i);
         step(op, 1'b0);
         total++;
         if (observed() !== model(op, 1'b0)) begin
            bad++;
            $display("FAIL sweep op=%b: got %h want %h", op, observed(), model(op, 1'b0));
         end
         if (illegal_op === 1'b1) n_illegal++;
         total++;
         if ((memWrite && mem_read) || (jump && jr) || (memToReg && !mem_read) ||
             (int'(Branch) + int'(jump) + int'(jr) > 1)) begin
            bad++;
            $display("FAIL invariant op=%b: got %h want consistent strobes", op, observed());
         end
      end
      total++;
      if (n_illegal != 55) begin
         bad++;
         $display("FAIL sweep_illegal_count: got %0d want 55", n_illegal);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         logic [5:0] op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                      : 6'($urandom_range(0, 10));
         logic fl = ($urandom_range(0, 4) == 0);
         step(op, fl);
         total++;
         if (observed() !== model(op, fl)) begin
            bad++;
            $display("FAIL random[%0d] op=%b flush=%b: got %h want %h", i, op, fl,
                     observed(), model(op, fl));
         end
      end
   endtask

   initial begin
      build_table();
      test_reset();
      test_sequence();
      test_addi_beq_jr();
      test_flush();
      test_async_reset();
      test_sweep();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
